routing_initiator_prog_lut: RTL and testbench



---
 rtl/routing_initiator_prog_lut.sv | 145 ++++++++++++++
 tb/tb_routing_initiator_prog_lut.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/routing_initiator_prog_lut.sv
// Programmable address-window router: maps a request address to a source route
// and target ID through NUM_RANGES runtime-configured windows, with one
// registered valid/ready output stage and a saturating decode-failure counter.
module routing_initiator_prog_lut #(
    parameter int unsigned NUM_RANGES   = 8,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned PATH_WIDTH   = 7,
    parameter int unsigned TARGET_WIDTH = 4,
    parameter int unsigned IDX_WIDTH    = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cfg_we,
    input  logic [IDX_WIDTH-1:0]    cfg_idx,
    input  logic [1:0]              cfg_field,
    input  logic [ADDR_WIDTH-1:0]   cfg_wdata,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_address,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [PATH_WIDTH-1:0]   lut_path,
    output logic [TARGET_WIDTH-1:0] transaction_target,
    output logic                    failed_decoding,
    output logic [15:0]             fail_count,
    input  logic                    fail_clear
);

    localparam int unsigned CNT_WIDTH = 16;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    localparam logic [1:0] FIELD_BASE  = 2'd0;
    localparam logic [1:0] FIELD_LIMIT = 2'd1;
    localparam logic [1:0] FIELD_ROUTE = 2'd2;

    // Window table
    logic [ADDR_WIDTH-1:0]   base_q   [NUM_RANGES];
    logic [ADDR_WIDTH-1:0]   limit_q  [NUM_RANGES];
    logic [PATH_WIDTH-1:0]   path_q   [NUM_RANGES];
    logic [TARGET_WIDTH-1:0] target_q [NUM_RANGES];
    logic [NUM_RANGES-1:0]   en_q;

    // Decode results
    logic                    hit_c;
    logic [PATH_WIDTH-1:0]   dec_path_c;
    logic [TARGET_WIDTH-1:0] dec_target_c;
    logic                    accept_c;

    // Output stage
    logic                    rsp_valid_q, rsp_valid_d;
    logic [PATH_WIDTH-1:0]   out_path_q, out_path_d;
    logic [TARGET_WIDTH-1:0] out_target_q, out_target_d;
    logic                    failed_q, failed_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

    // Config port: out-of-range indices match no entry and are dropped
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_RANGES); i++) begin
                base_q[i]   <= '0;
                limit_q[i]  <= '0;
                path_q[i]   <= '0;
                target_q[i] <= '0;
            end
            en_q <= '0;
        end else if (cfg_we) begin
            for (int i = 0; i < int'(NUM_RANGES); i++) begin
                if (cfg_idx == IDX_WIDTH'(i)) begin
                    case (cfg_field)
                        FIELD_BASE:  base_q[i]  <= cfg_wdata;
                        FIELD_LIMIT: limit_q[i] <= cfg_wdata;
                        FIELD_ROUTE: begin
                            path_q[i]   <= cfg_wdata[PATH_WIDTH-1:0];
                            target_q[i] <= cfg_wdata[PATH_WIDTH +: TARGET_WIDTH];
                        end
                        default:     en_q[i]    <= cfg_wdata[0];
                    endcase
                end
            end
        end
    end

    // Window match; scanning from the top down leaves the lowest matching index in place
    always_comb begin
        hit_c        = 1'b0;
        dec_path_c   = '0;
        dec_target_c = '0;
        for (int i = int'(NUM_RANGES) - 1; i >= 0; i--) begin
            if (en_q[i] && (base_q[i] <= req_address) && (req_address <= limit_q[i])) begin
                hit_c        = 1'b1;
                dec_path_c   = path_q[i];
                dec_target_c = target_q[i];
            end
        end
    end

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign accept_c  = req_valid && req_ready;

    // Output register and failure counter next-state
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        out_path_d   = out_path_q;
        out_target_d = out_target_q;
        failed_d     = failed_q;
        cnt_d        = cnt_q;
        if (accept_c) begin
            rsp_valid_d  = 1'b1;
            out_path_d   = dec_path_c;
            out_target_d = dec_target_c;
            failed_d     = !hit_c;
        end else if (rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
        if (fail_clear) begin
            cnt_d = '0;
        end else if (accept_c && !hit_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Output stage state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid_q  <= 1'b0;
            out_path_q   <= '0;
            out_target_q <= '0;
            failed_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            out_path_q   <= out_path_d;
            out_target_q <= out_target_d;
            failed_q     <= failed_d;
            cnt_q        <= cnt_d;
        end
    end

    assign rsp_valid          = rsp_valid_q;
    assign lut_path           = out_path_q;
    assign transaction_target = out_target_q;
    assign failed_decoding    = failed_q;
    assign fail_count         = cnt_q;

endmodule

// File: tb/tb_routing_initiator_prog_lut.sv
// Bench for routing_initiator_prog_lut: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// table-lookup reference model.
module tb_routing_initiator_prog_lut;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_idx = '0;
    logic [1:0]  cfg_field = '0;
    logic [31:0] cfg_wdata = '0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_address = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [6:0]  lut_path;
    logic [3:0]  transaction_target;
    logic        failed_decoding;
    logic [15:0] fail_count;
    logic        fail_clear = 1'b0;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    routing_initiator_prog_lut dut (
        .clock              (clock),
        .reset              (reset),
        .cfg_we             (cfg_we),
        .cfg_idx            (cfg_idx),
        .cfg_field          (cfg_field),
        .cfg_wdata          (cfg_wdata),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_address        (req_address),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .lut_path           (lut_path),
        .transaction_target (transaction_target),
        .failed_decoding    (failed_decoding),
        .fail_count         (fail_count),
        .fail_clear         (fail_clear)
    );

    always #5 clock = ~clock;

    // Reference model state
    logic [31:0] m_base  [8];
    logic [31:0] m_limit [8];
    logic [6:0]  m_path  [8];
    logic [3:0]  m_tgt   [8];
    logic [7:0]  m_en = '0;
    logic        m_valid = 1'b0;
    logic [6:0]  m_opath = '0;
    logic [3:0]  m_otgt = '0;
    logic        m_ofail = 1'b0;
    int          m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // First enabled window containing the address wins
    function automatic void lookup(input logic [31:0] a, output logic hit,
                                   output logic [6:0] p, output logic [3:0] t);
        hit = 1'b0; p = '0; t = '0;
        for (int i = 0; i < 8; i++) begin
            if (m_en[i] && a >= m_base[i] && a <= m_limit[i]) begin
                hit = 1'b1; p = m_path[i]; t = m_tgt[i];
                break;
            end
        end
    endfunction

    logic       lk_hit;
    logic [6:0] lk_path;
    logic [3:0] lk_tgt;
    logic       lk_acc;

    // Model update at each rising edge from the bench's own inputs
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                m_base[i] <= '0; m_limit[i] <= '0; m_path[i] <= '0; m_tgt[i] <= '0;
            end
            m_en <= '0; m_valid <= 1'b0; m_opath <= '0; m_otgt <= '0;
            m_ofail <= 1'b0; m_cnt <= 0;
        end else begin
            lk_acc = req_valid && (!m_valid || rsp_ready);
            lookup(req_address, lk_hit, lk_path, lk_tgt);
            if (lk_acc) begin
                m_valid <= 1'b1; m_opath <= lk_path; m_otgt <= lk_tgt; m_ofail <= !lk_hit;
            end else if (rsp_ready) begin
                m_valid <= 1'b0;
            end
            if (fail_clear) m_cnt <= 0;
            else if (lk_acc && !lk_hit && m_cnt < 65535) m_cnt <= m_cnt + 1;
            if (cfg_we && cfg_idx < 4'd8) begin
                case (cfg_field)
                    2'd0: m_base[cfg_idx[2:0]]  <= cfg_wdata;
                    2'd1: m_limit[cfg_idx[2:0]] <= cfg_wdata;
                    2'd2: begin
                        m_path[cfg_idx[2:0]] <= cfg_wdata[6:0];
                        m_tgt[cfg_idx[2:0]]  <= cfg_wdata[10:7];
                    end
                    default: m_en[cfg_idx[2:0]] <= cfg_wdata[0];
                endcase
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(posedge clock) begin
        #1;
        if (check_en) begin
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("req_ready", 32'(req_ready), 32'(!m_valid || rsp_ready));
            chk("lut_path", 32'(lut_path), 32'(m_opath));
            chk("target", 32'(transaction_target), 32'(m_otgt));
            chk("failed", 32'(failed_decoding), 32'(m_ofail));
            chk("fail_count", 32'(fail_count), 32'(m_cnt));
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic idle();
        cfg_we = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1; fail_clear = 1'b0;
    endtask

    task automatic cfg(input int idx, input int field, input logic [31:0] data);
        cfg_we = 1'b1; cfg_idx = 4'(idx); cfg_field = 2'(field); cfg_wdata = data;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic req(input logic [31:0] a);
        req_valid = 1'b1; req_address = a; rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic program0();
        cfg(0, 0, 32'h1000_0000);
        cfg(0, 1, 32'h103F_FFFF);
        cfg(0, 2, 32'h0000_0080);
        cfg(0, 3, 32'h1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        step();
        #1 reset = 1'b1;
        step();
        check_en = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_req_ready", 32'(req_ready), 32'h1);
        chk("reset_fail_count", 32'(fail_count), 32'h0);

        // Empty table: every lookup fails
        req(32'h1000_0000);
        chk("empty_valid", 32'(rsp_valid), 32'h1);
        chk("empty_failed", 32'(failed_decoding), 32'h1);
        chk("empty_path", 32'(lut_path), 32'h0);
        chk("empty_target", 32'(transaction_target), 32'h0);
        chk("empty_count", 32'(fail_count), 32'h1);

        // Inclusive limit, first address past it misses
        program0();
        req(32'h103F_FFFF);
        chk("limit_hit_failed", 32'(failed_decoding), 32'h0);
        chk("limit_hit_target", 32'(transaction_target), 32'h1);
        req(32'h1040_0000);
        chk("past_limit_failed", 32'(failed_decoding), 32'h1);

        // Overlapping windows: lowest index wins; upper route bits are ignored
        cfg(1, 0, 32'h1000_0000);
        cfg(1, 1, 32'h1FFF_FFFF);
        cfg(1, 2, 32'hFFFF_F655);
        cfg(1, 3, 32'h1);
        req(32'h1000_1000);
        chk("prio_target", 32'(transaction_target), 32'h1);
        cfg(0, 3, 32'h0);
        req(32'h1000_1000);
        chk("fallback_target", 32'(transaction_target), 32'hC);
        chk("fallback_path", 32'(lut_path), 32'h55);

        // Backpressure holds the first result and stalls the second request
        idle();
        step();
        req_valid = 1'b1; req_address = 32'h1000_1000; rsp_ready = 1'b0;
        step();
        req_address = 32'h0000_0010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            chk("bp_valid", 32'(rsp_valid), 32'h1);
            chk("bp_target", 32'(transaction_target), 32'hC);
            chk("bp_failed", 32'(failed_decoding), 32'h0);
        end
        rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        chk("bp_second_valid", 32'(rsp_valid), 32'h1);
        chk("bp_second_failed", 32'(failed_decoding), 32'h1);
        step();
        chk("bp_drained", 32'(rsp_valid), 32'h0);

        // Lookup in the same cycle as an enabling write sees the old table
        cfg(1, 3, 32'h0);
        cfg_we = 1'b1; cfg_idx = 4'd0; cfg_field = 2'd3; cfg_wdata = 32'h1;
        req(32'h1000_0100);
        cfg_we = 1'b0;
        chk("same_cycle_failed", 32'(failed_decoding), 32'h1);
        req(32'h1000_0100);
        chk("next_cycle_failed", 32'(failed_decoding), 32'h0);
        chk("next_cycle_target", 32'(transaction_target), 32'h1);

        // Out-of-range index must not touch any entry
        cfg(8, 0, 32'h2000_0000);
        cfg(15, 3, 32'h0);
        req(32'h1000_0100);
        chk("oob_write_ignored", 32'(failed_decoding), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cfg_we     = ($urandom_range(0, 3) == 0);
            cfg_idx    = 4'($urandom_range(0, 11));
            cfg_field  = 2'($urandom_range(0, 3));
            cfg_wdata  = (cfg_field < 2'd2) ? 32'($urandom_range(0, 255)) : $urandom;
            req_valid  = ($urandom_range(0, 3) != 0);
            rsp_ready  = ($urandom_range(0, 3) != 0);
            fail_clear = ($urandom_range(0, 31) == 0);
            req_address = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
            step();
        end
        idle();
        step();

        // Reset while a hit is pending drops it and wipes the table
        program0();
        req_valid = 1'b1; req_address = 32'h1000_0100; rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        do_reset();
        chk("midreset_valid", 32'(rsp_valid), 32'h0);
        chk("midreset_count", 32'(fail_count), 32'h0);
        idle();
        req(32'h1000_0100);
        chk("post_reset_failed", 32'(failed_decoding), 32'h1);

        // Counter saturation, then clear beating a simultaneous increment
        req_valid = 1'b1; req_address = 32'h1000_0100; rsp_ready = 1'b1;
        for (int n = 0; n < 65534; n++) step();
        chk("count_full", 32'(fail_count), 32'hFFFF);
        step();
        chk("count_saturated", 32'(fail_count), 32'hFFFF);
        fail_clear = 1'b1;
        step();
        fail_clear = 1'b0;
        req_valid = 1'b0;
        chk("clear_wins", 32'(fail_count), 32'h0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
